bf_input_conditioner: RTL

- Front-end stage directly upstream of the boolfuck interpreter core. It turns raw, asynchronous, bouncing panel inputs into clean synchronous levels on the core's lft/rgt/ctl/key inputs. The core does its own rising-edge detection.
- Synchronizes, debounces and one-hot-qualifies the 8-key pad, so the core never sees a chord or a bounce.

---
 rtl/bf_input_conditioner.sv | 107 ++++++++++
 1 files changed

// File: rtl/bf_input_conditioner.sv
// bf_input_conditioner: synchronize, debounce and one-hot-qualify panel inputs; `define BF_INPUT_AUTO_REPEAT_EN adds lft/rgt auto-repeat
module bf_input_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_LIMIT      = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_lft,
  input  logic       raw_rgt,
  input  logic       raw_ctl,
  input  logic [7:0] raw_key,
  output logic       lft,
  output logic       rgt,
  output logic       ctl,
  output logic [7:0] key,
  output logic       chord
);
  localparam int CW = $clog2(DB_LIMIT);
  typedef enum logic [1:0] {IDLE, HELD, LOCK} state_e;
  logic [10:0] raw, s, db;
  logic [10:0] sync_q [SYNC_STAGES];
  state_e state_q, state_d;
  logic [7:0] kc_q, kc_d, key_q, key_d, qk;
  logic chord_q, chord_d, one_hot;
  if (SYNC_STAGES < 2 || DB_LIMIT < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("bf_input_conditioner: invalid parameters");
  end
  assign raw = {raw_key, raw_ctl, raw_rgt, raw_lft};
  assign s = sync_q[SYNC_STAGES-1];
  // synchronizer chain shared by all eleven raw bits
  always_ff @(posedge clk)
    if (!rst_n) for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  for (genvar g = 0; g < 11; g++) begin : g_db
    logic q_q;
    logic [CW-1:0] cnt_q;
    assign db[g] = q_q;
    // level flips only after DB_LIMIT consecutive disagreeing samples
    always_ff @(posedge clk)
      if (!rst_n) begin
        q_q   <= 1'b0;
        cnt_q <= '0;
      end else if (s[g] == q_q) cnt_q <= '0;
      else if (cnt_q == CW'(DB_LIMIT-1)) begin
        q_q   <= s[g];
        cnt_q <= '0;
      end else cnt_q <= cnt_q + 1'b1;
  end
  assign ctl = db[2];
  assign qk = db[10:3];
  assign one_hot = (qk != '0) && ((qk & (qk - 8'd1)) == '0);
  // keypad state register and registered outputs
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      kc_q    <= '0;
      key_q   <= '0;
      chord_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kc_q    <= kc_d;
      key_q   <= key_d;
      chord_q <= chord_d;
    end
  // keypad next state: any chord locks until every key is released
  always_comb begin
    state_d = state_q;
    kc_d = kc_q;
    case (state_q)
      IDLE: if (one_hot) begin
        state_d = HELD;
        kc_d = qk;
      end else if (qk != '0) state_d = LOCK;
      HELD: state_d = (qk == kc_q) ? HELD : (qk == '0) ? IDLE : LOCK;
      default: state_d = (qk == '0) ? IDLE : LOCK;
    endcase
  end
  // keypad outputs decoded from the next state
  always_comb begin
    key_d = (state_d == HELD) ? kc_d : '0;
    chord_d = (state_d == LOCK);
  end
  assign key = key_q;
  assign chord = chord_q;
`ifdef BF_INPUT_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD);
  logic [1:0] dip;
  for (genvar g = 0; g < 2; g++) begin : g_rep
    logic [RW-1:0] rc_q;
    assign dip[g] = db[g] && (rc_q == RW'(REPEAT_DELAY-1));
    // hold-time counter; wraps back to the first dip point every REPEAT_PERIOD
    always_ff @(posedge clk)
      if (!rst_n || !db[g]) rc_q <= '0;
      else rc_q <= (rc_q == RW'(REPEAT_DELAY+REPEAT_PERIOD-2)) ? RW'(REPEAT_DELAY-1) : rc_q + 1'b1;
  end
  assign lft = db[0] & ~dip[0];
  assign rgt = db[1] & ~dip[1];
`else
  assign lft = db[0];
  assign rgt = db[1];
`endif
endmodule
